// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// Runs signed/unsigned mult, div, madd and msub over a fixed number of busy cycles.
// It also performs single-cycle mthi/mtlo writes. An int_req in IDLE blocks every
// architectural write; once an op has started, int_req does not stop it.
module mdu_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    input  logic             start_i,
    input  logic             int_req_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    localparam logic [CntW-1:0] MulLatC = CntW'(MUL_LAT);
    localparam logic [CntW-1:0] DivLatC = CntW'(DIV_LAT);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [3:0] OpMult  = 4'b0000;
    localparam logic [3:0] OpMultu = 4'b0001;
    localparam logic [3:0] OpDiv   = 4'b0010;
    localparam logic [3:0] OpDivu  = 4'b0011;
    localparam logic [3:0] OpMthi  = 4'b0100;
    localparam logic [3:0] OpMtlo  = 4'b0101;
    localparam logic [3:0] OpMadd  = 4'b0110;
    localparam logic [3:0] OpMaddu = 4'b0111;
    localparam logic [3:0] OpMsub  = 4'b1000;
    localparam logic [3:0] OpMsubu = 4'b1001;

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [3:0]        op_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic              div_zero_q, div_zero_d;

    logic              op_is_arith, op_is_div, accept, done;

    logic               signed_op;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, divisor, quo_mag, rem_mag, quo, rem;

    // Decode the incoming op and form the launch / completion strobes
    always_comb begin
        op_is_arith = 1'b0;
        op_is_div   = 1'b0;
        case (op_i)
            OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu: op_is_arith = 1'b1;
            OpDiv, OpDivu: begin
                op_is_arith = 1'b1;
                op_is_div   = 1'b1;
            end
            default: ;
        endcase
        accept = (state_q == StIdle) && start_i && !int_req_i && op_is_arith;
        done   = (state_q == StRun) && (cnt_q == CntOne);
    end

    // State register and latency down-counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the counter is loaded on accept and reaching zero returns to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRun;
                    cnt_d   = op_is_div ? DivLatC : MulLatC;
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntOne;
                if (done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o = (state_q == StRun);
    end

    // Operand latches: snapshot operands, op and the accumulator at launch
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            acc_q <= '0;
        end else if (accept) begin
            a_q   <= a_i;
            b_q   <= b_i;
            op_q  <= op_i;
            acc_q <= {hi_q, lo_q};
        end
    end

    // Multiply datapath: sign- or zero-extend both operands, keep the low 2*WIDTH bits
    always_comb begin
        signed_op = (op_q == OpMult) || (op_q == OpDiv) || (op_q == OpMadd) ||
                    (op_q == OpMsub);
        a_ext = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod  = a_ext * b_ext;
    end

    // Divide datapath on magnitudes. This keeps MIN/-1 well defined: it wraps to MIN rem 0.
    always_comb begin
        a_neg   = signed_op && a_q[WIDTH-1];
        b_neg   = signed_op && b_q[WIDTH-1];
        a_mag   = a_neg ? -a_q : a_q;
        b_mag   = b_neg ? -b_q : b_q;
        // Avoid a divide by zero in the datapath; the result is discarded in that case
        divisor = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        quo_mag = a_mag / divisor;
        rem_mag = a_mag % divisor;
        quo     = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
        rem     = a_neg ? -rem_mag : rem_mag;
    end

    // HI/LO next state: write the result at completion, or do mthi/mtlo in an idle cycle
    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;
        if (done) begin
            case (op_q)
                OpMult, OpMultu:  {hi_d, lo_d} = prod;
                OpMadd, OpMaddu:  {hi_d, lo_d} = acc_q + prod;
                OpMsub, OpMsubu:  {hi_d, lo_d} = acc_q - prod;
                OpDiv, OpDivu: begin
                    if (b_q == '0) begin
                        div_zero_d = 1'b1;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
                default: ;
            endcase
        end else if ((state_q == StIdle) && !start_i && !int_req_i) begin
            if (op_i == OpMthi) begin
                hi_d = a_i;
            end else if (op_i == OpMtlo) begin
                lo_d = a_i;
            end
        end
    end

    // Architectural HI/LO and divide-by-zero pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: a 32-bit instance (5/10 cycle latency) and a
// 16-bit instance (1/1 cycle latency) share stimulus, and sel picks the active one.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        start, int_req, sel;

    logic        busy32, dz32, busy16, dz16;
    logic [31:0] hi32, lo32;
    logic [15:0] hi16, lo16;
    logic        busy_s, dz_s;
    logic [31:0] hi_s, lo_s;

    always #5 clk = ~clk;

    mdu_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) u_mdu32 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .a_i        (a),
        .b_i        (b),
        .op_i       (sel ? 4'hF : op),
        .start_i    (start & ~sel),
        .int_req_i  (int_req),
        .busy_o     (busy32),
        .hi_o       (hi32),
        .lo_o       (lo32),
        .div_zero_o (dz32)
    );

    mdu_unit #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(1)) u_mdu16 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .a_i        (a[15:0]),
        .b_i        (b[15:0]),
        .op_i       (sel ? op : 4'hF),
        .start_i    (start & sel),
        .int_req_i  (int_req),
        .busy_o     (busy16),
        .hi_o       (hi16),
        .lo_o       (lo16),
        .div_zero_o (dz16)
    );

    assign busy_s = sel ? busy16 : busy32;
    assign dz_s   = sel ? dz16 : dz32;
    assign hi_s   = sel ? {16'h0, hi16} : hi32;
    assign lo_s   = sel ? {16'h0, lo16} : lo32;

    typedef struct {
        string       name;
        logic        sel;
        logic [3:0]  op;
        logic [31:0] a, b, hi0, lo0, ehi, elo;
        logic        edz;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi, lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic s, input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        sel = s; start = 1'b0; int_req = 1'b0; op = 4'h4; a = h;
        @(negedge clk);
        op = 4'h5; a = l;
        @(negedge clk);
        op = 4'hF;
    endtask

    // mode 0: quiet, 1: start/mthi disturbance while busy, 2: int_req pulse while busy
    task automatic run_op(input string name, input logic s, input logic [3:0] o,
                          input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int lat, input int mode);
        exp_t e;
        int   cyc;
        e.name = name; e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = lat;
        @(negedge clk);
        sel = s; op = o; a = va; b = vb; start = 1'b1;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0; op = 4'hF;
        cyc = 0;
        while (busy_s && cyc < 64) begin
            cyc++;
            if (mode == 1) begin
                if (cyc <= 2) begin
                    start = 1'b1; op = 4'h3; a = 32'h1; b = 32'h1;
                end else if (cyc == 3) begin
                    start = 1'b0; op = 4'h4; a = 32'hDEADBEEF;
                end else begin
                    start = 1'b0; op = 4'hF;
                end
            end
            if (mode == 2) int_req = (cyc == 2);
            @(negedge clk);
        end
        start = 1'b0; op = 4'hF; int_req = 1'b0;
        e = sbq.pop_front();
        check({e.name, " busy cycles"}, cyc, e.lat);
        check({e.name, " hi"}, hi_s, e.hi);
        check({e.name, " lo"}, lo_s, e.lo);
        check({e.name, " div_zero"}, {31'h0, dz_s}, {31'h0, e.dz});
        @(negedge clk);
        check({e.name, " div_zero pulse ends"}, {31'h0, dz_s}, 32'h0);
        check({e.name, " no queued op"}, {31'h0, busy_s}, 32'h0);
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{"mult32",   1'b0, 4'h0, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h0,
                     32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 5};
        vecs[1]  = '{"multu32",  1'b0, 4'h1, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h0,
                     32'h00000002, 32'hFFFFFFFA, 1'b0, 5};
        vecs[2]  = '{"div32",    1'b0, 4'h2, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0,
                     32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 10};
        vecs[3]  = '{"divu32_z", 1'b0, 4'h3, 32'h7, 32'h0, 32'h11111111, 32'h22222222,
                     32'h11111111, 32'h22222222, 1'b1, 10};
        vecs[4]  = '{"maddu32",  1'b0, 4'h7, 32'h2, 32'h3, 32'h12345678, 32'h9ABCDEF0,
                     32'h12345678, 32'h9ABCDEF6, 1'b0, 5};
        vecs[5]  = '{"msub32",   1'b0, 4'h8, 32'h1, 32'h1, 32'h0, 32'h0,
                     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5};
        vecs[6]  = '{"div32_min", 1'b0, 4'h2, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h5,
                     32'h00000000, 32'h80000000, 1'b0, 10};
        vecs[7]  = '{"div32_negb", 1'b0, 4'h2, 32'h7, 32'hFFFFFFFE, 32'h0, 32'h0,
                     32'h00000001, 32'hFFFFFFFD, 1'b0, 10};
        vecs[8]  = '{"madd32",   1'b0, 4'h6, 32'hFFFFFFFF, 32'h5, 32'h0, 32'h10,
                     32'h00000000, 32'h0000000B, 1'b0, 5};
        vecs[9]  = '{"divu32",   1'b0, 4'h3, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0,
                     32'h00000001, 32'h7FFFFFFC, 1'b0, 10};
        vecs[10] = '{"mult16",   1'b1, 4'h0, 32'hFFFE, 32'h3, 32'h0, 32'h0,
                     32'hFFFF, 32'hFFFA, 1'b0, 1};
        vecs[11] = '{"multu16",  1'b1, 4'h1, 32'hFFFE, 32'h3, 32'h0, 32'h0,
                     32'h0002, 32'hFFFA, 1'b0, 1};
        vecs[12] = '{"div16",    1'b1, 4'h2, 32'hFFF9, 32'h2, 32'h0, 32'h0,
                     32'hFFFF, 32'hFFFD, 1'b0, 1};
        vecs[13] = '{"divu16_z", 1'b1, 4'h3, 32'h7, 32'h0, 32'h1111, 32'h2222,
                     32'h1111, 32'h2222, 1'b1, 1};
        vecs[14] = '{"msubu16",  1'b1, 4'h9, 32'h1, 32'h1, 32'h0, 32'h0,
                     32'hFFFF, 32'hFFFF, 1'b0, 1};

        rst_n = 1'b0; a = '0; b = '0; op = 4'hF; start = 1'b0; int_req = 1'b0; sel = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("reset busy", {31'h0, busy_s}, 32'h0);
            check("reset hi", hi_s, 32'h0);
            check("reset lo", lo_s, 32'h0);
            check("reset div_zero", {31'h0, dz_s}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            preload(vecs[i].sel, vecs[i].hi0, vecs[i].lo0);
            run_op(vecs[i].name, vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].ehi, vecs[i].elo, vecs[i].edz, vecs[i].lat, 0);
        end

        // Start held and mthi while busy are both ignored
        preload(1'b0, 32'h0, 32'h0);
        run_op("mult_disturbed", 1'b0, 4'h0, 32'h5, 32'h7, 32'h0, 32'h23, 1'b0, 5, 1);

        // int_req blocks mtlo, start, and mthi-with-start and undefined codes are no-ops
        preload(1'b0, 32'h0, 32'h55);
        @(negedge clk);
        op = 4'h5; a = 32'hAAAA; int_req = 1'b1;
        @(negedge clk);
        int_req = 1'b0; op = 4'hF;
        check("mtlo with int_req", lo_s, 32'h55);
        op = 4'h0; a = 32'h2; b = 32'h3; start = 1'b1; int_req = 1'b1;
        @(negedge clk);
        check("start with int_req", {31'h0, busy_s}, 32'h0);
        int_req = 1'b0; op = 4'hA;
        @(negedge clk);
        check("start with undefined op", {31'h0, busy_s}, 32'h0);
        op = 4'h4; a = 32'hFFFF;
        @(negedge clk);
        check("start with mthi", hi_s, 32'h0);
        start = 1'b0; op = 4'hF;

        // int_req mid-run does not cancel the op
        run_op("mult_intreq", 1'b0, 4'h0, 32'h6, 32'h7, 32'h0, 32'h2A, 1'b0, 5, 2);

        // Asynchronous reset during a divide
        preload(1'b0, 32'hCAFE, 32'hBEEF);
        @(negedge clk);
        sel = 1'b0; op = 4'h2; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", {31'h0, busy_s}, 32'h0);
        check("async reset hi", hi_s, 32'h0);
        check("async reset lo", lo_s, 32'h0);
        check("async reset div_zero", {31'h0, dz_s}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mult_after_reset", 1'b0, 4'h0, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0, 5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
